// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite compositor: layer and fade
// encodings, the sprite palette and the title fade scaler.
package sprite_pkg;

    typedef enum logic [1:0] {BG, OBJ, TITLE} layer_t;
    typedef enum logic [1:0] {SHOW, FADE, HIDDEN} fade_t;

    localparam logic [23:0] BG_COLOR        = 24'h202020;
    localparam logic [3:0]  TRANSPARENT_IDX = 4'd0;

    localparam logic [23:0] PALETTE [16] = '{
        24'h000000, 24'h000080, 24'h008000, 24'h008080,
        24'h800000, 24'h800080, 24'h808000, 24'hC0C0C0,
        24'h808080, 24'h0000FF, 24'h00FF00, 24'h00FFFF,
        24'hFF0000, 24'hFF00FF, 24'hFFFF00, 24'hFFFFFF
    };

    // Level 15 multiplies by 16 and shifts back, so a fully shown title is unscaled.
    function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [3:0] level);
        logic [11:0] prod;
        prod = 12'(c) * (12'(level) + 12'd1);
        return prod[11:4];
    endfunction

endpackage

// File: rtl/title_fader.sv
// Title fade controller: VS falling-edge detector plus SHOW/FADE/HIDDEN FSM
// that steps the title brightness down once per frame.
module title_fader
    import sprite_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       VGA_VS,
    input  logic       Game_Start_On,
    output logic [3:0] level,
    output logic       hidden
);

    fade_t      state_q, state_d;
    logic [3:0] level_q, level_d;
    logic       vs_q;
    logic       gs_q;
    logic       frame_tick;
    logic       gs_fall;

    assign frame_tick = vs_q & ~VGA_VS;
    assign gs_fall    = gs_q & ~Game_Start_On;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= SHOW;
            level_q <= 4'd15;
            vs_q    <= 1'b1;
            gs_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            vs_q    <= VGA_VS;
            gs_q    <= Game_Start_On;
        end
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        case (state_q)
            SHOW: begin
                // A start edge wins over a coincident frame tick: fade begins at full level.
                level_d = 4'd15;
                if (gs_fall) state_d = FADE;
            end
            FADE: begin
                if (Game_Start_On) begin
                    state_d = SHOW;
                    level_d = 4'd15;
                end else if (frame_tick) begin
                    if (level_q == 4'd0) state_d = HIDDEN;
                    else                 level_d = level_q - 4'd1;
                end
            end
            HIDDEN: begin
                level_d = 4'd0;
                if (Game_Start_On) begin
                    state_d = SHOW;
                    level_d = 4'd15;
                end
            end
            default: begin
                state_d = SHOW;
                level_d = 4'd15;
            end
        endcase
    end

    assign level  = level_q;
    assign hidden = (state_q == HIDDEN);

endmodule

// File: rtl/sprite_compositor.sv
// Three-stage sprite compositor: layer select and ROM fetch, alignment with
// the synchronous ROM, then palette lookup, title fade and blanking.
module sprite_compositor
    import sprite_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        VGA_VS,
    input  logic        blank_n,
    input  logic        Game_Start_On,
    input  logic        title_is_obj,
    input  logic [17:0] title_addr,
    input  logic        obj_is_obj,
    input  logic [17:0] obj_addr,
    output logic [17:0] rom_addr,
    input  logic [3:0]  rom_data,
    output logic [7:0]  Red,
    output logic [7:0]  Green,
    output logic [7:0]  Blue
);

    logic [3:0]  fade_level;
    logic        fade_hidden;

    layer_t      layer_d, layer_s1_q, layer_s2_q;
    logic [17:0] rom_addr_d, rom_addr_q;
    logic        blank_s1_q, blank_s2_q;
    logic [3:0]  level_s1_q, level_s2_q;
    logic [23:0] rgb_d, rgb_q;
    logic [23:0] pal;

    title_fader u_fader (
        .Clk           (Clk),
        .Reset         (Reset),
        .VGA_VS        (VGA_VS),
        .Game_Start_On (Game_Start_On),
        .level         (fade_level),
        .hidden        (fade_hidden)
    );

    always_comb begin
        layer_d    = BG;
        rom_addr_d = 18'd0;
        if (title_is_obj && !fade_hidden) begin
            layer_d    = TITLE;
            rom_addr_d = title_addr;
        end else if (obj_is_obj) begin
            layer_d    = OBJ;
            rom_addr_d = obj_addr;
        end
    end

    // rom_data arrives alongside the stage-2 controls, so stage 3 consumes it directly.
    always_comb begin
        pal   = PALETTE[rom_data];
        rgb_d = BG_COLOR;
        if (!blank_s2_q) begin
            rgb_d = 24'h000000;
        end else if (layer_s2_q != BG && rom_data != TRANSPARENT_IDX) begin
            if (layer_s2_q == TITLE)
                rgb_d = {scale_chan(pal[23:16], level_s2_q),
                         scale_chan(pal[15:8],  level_s2_q),
                         scale_chan(pal[7:0],   level_s2_q)};
            else
                rgb_d = pal;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rom_addr_q <= 18'd0;
            layer_s1_q <= BG;
            blank_s1_q <= 1'b0;
            level_s1_q <= 4'd0;
            layer_s2_q <= BG;
            blank_s2_q <= 1'b0;
            level_s2_q <= 4'd0;
            rgb_q      <= 24'h000000;
        end else begin
            rom_addr_q <= rom_addr_d;
            layer_s1_q <= layer_d;
            blank_s1_q <= blank_n;
            level_s1_q <= fade_level;
            layer_s2_q <= layer_s1_q;
            blank_s2_q <= blank_s1_q;
            level_s2_q <= level_s1_q;
            rgb_q      <= rgb_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign Red      = rgb_q[23:16];
    assign Green    = rgb_q[15:8];
    assign Blue     = rgb_q[7:0];

endmodule
